// File: rtl/rtp_pkg.sv
// Shared types and constants for the RTP result path: collector FSM state,
// the "no hit" marker and the hit record layout used on the RTP output side.
package rtp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } coll_state_t;

  // +inf as an IEEE-754 single: a ray that never reported a hit
  localparam logic [31:0] MISS_T = 32'h7F80_0000;

  typedef struct packed {
    logic [31:0] ray_id;
    logic [31:0] hitT;
  } hit_rec_t;

  // Unsigned pattern compare orders non-negative floats correctly
  function automatic logic [31:0] hit_min(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rtp_result_ram.sv
// Result RAM: one combinational read port, one synchronous write port.
// Each word holds {seen, hitT}.
module rtp_result_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 33
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rtp_hit_collector.sv
// Collects per-ray hit records, keeping the nearest hitT per ray, then exposes
// the result RAM through a one-cycle-latency readback port once DONE.
module rtp_hit_collector #(
  parameter int          NUM_RAYS = 1024,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] MISS_T   = rtp_pkg::MISS_T
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ray_id,
  input  logic [31:0]       in_hitT,
  input  logic              rtp_finish,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_hit,
  output logic [ADDR_W:0]   collected,
  output logic [15:0]       dup_count,
  output logic              oob_err,
  output logic              incomplete,
  output logic              busy,
  output logic              done,
  output logic [63:0]       cycle_count
);

  import rtp_pkg::*;

  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(NUM_RAYS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_RAYS - 1);

  coll_state_t       state;
  logic [ADDR_W-1:0] clr_addr;
  logic              finish_seen;

  logic              xfer, in_oob, start_ok;
  logic              clear_last, pipe_empty, complete;

  logic              s1_valid, s1_oob;
  logic [ADDR_W-1:0] s1_addr;
  logic [31:0]       s1_hitT, s1_stored;
  logic              s1_seen, fwd;

  logic              s2_valid, s2_oob, s2_seen, s2_live;
  logic [ADDR_W-1:0] s2_addr;
  logic [31:0]       s2_hitT, s2_stored, s2_new;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [32:0]       ram_wdata, ram_rdata;

  logic [31:0]       rb_data;
  logic              rb_hit;

  assign in_ready   = (state == ST_COLLECT);
  assign busy       = (state == ST_CLEAR) || (state == ST_COLLECT);
  assign done       = (state == ST_DONE);
  assign xfer       = in_valid & in_ready;
  assign in_oob     = (in_ray_id >= 32'(NUM_RAYS));
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign clear_last = (state == ST_CLEAR) && (clr_addr == LAST_ADDR);

  // A record accepted this cycle counts as in flight, so a same-cycle finish drains it
  assign pipe_empty = ~xfer & ~s1_valid & ~s2_valid;
  assign complete   = (state == ST_COLLECT) && pipe_empty &&
                      ((collected == FULL_CNT) || rtp_finish || finish_seen);

  assign s2_live = s2_valid & ~s2_oob;
  assign s2_new  = s2_seen ? hit_min(s2_stored, s2_hitT) : s2_hitT;

  // S2 writes at the end of this cycle, so S1 must not trust the RAM for the same ray
  assign fwd       = s1_valid & ~s1_oob & s2_live & (s1_addr == s2_addr);
  assign s1_stored = fwd ? s2_new : ram_rdata[31:0];
  assign s1_seen   = fwd | ram_rdata[32];

  assign ram_raddr = (state == ST_DONE) ? rd_addr : s1_addr;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s2_addr;
    ram_wdata = {1'b1, s2_new};
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = {1'b0, MISS_T};
    end else if (s2_live) begin
      ram_we    = 1'b1;
    end
  end

  rtp_result_ram #(
    .DEPTH  (NUM_RAYS),
    .ADDR_W (ADDR_W),
    .WIDTH  (33)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      clr_addr    <= '0;
      finish_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_CLEAR;
            clr_addr    <= '0;
            finish_seen <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clear_last) state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (rtp_finish) finish_seen <= 1'b1;
          if (complete) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= xfer;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clock) begin
    s1_oob    <= in_oob;
    s1_addr   <= in_ray_id[ADDR_W-1:0];
    s1_hitT   <= in_hitT;
    s2_oob    <= s1_oob;
    s2_addr   <= s1_addr;
    s2_hitT   <= s1_hitT;
    s2_stored <= s1_stored;
    s2_seen   <= s1_seen;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      collected  <= '0;
      dup_count  <= '0;
      oob_err    <= 1'b0;
      incomplete <= 1'b0;
    end else if (clear_last) begin
      collected  <= '0;
      dup_count  <= '0;
      oob_err    <= 1'b0;
      incomplete <= 1'b0;
    end else if (state == ST_COLLECT) begin
      if (s2_valid && s2_oob) oob_err <= 1'b1;
      if (s2_live) begin
        if (!s2_seen)                collected <= collected + (ADDR_W+1)'(1);
        else if (dup_count != '1)    dup_count <= dup_count + 16'd1;
      end
      if (complete && (collected != FULL_CNT)) incomplete <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      cycle_count <= '0;
    end else if (busy) begin
      cycle_count <= cycle_count + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      rb_data <= '0;
      rb_hit  <= 1'b0;
    end else if ((state == ST_DONE) && rd_en) begin
      rb_data <= ram_rdata[31:0];
      rb_hit  <= ram_rdata[32];
    end
  end

  assign rd_data = done ? rb_data : '0;
  assign rd_hit  = done & rb_hit;

endmodule

// File: doc/rtp_hit_collector.md
# rtp_hit_collector

Result-side sink for the ray-tracing processor. It accepts per-ray hit records (ray id, hitT) as the traversal core retires them and stores the nearest hit per ray in a result RAM. It tracks completion, duplicates and errors, and counts the cycles from start to done. Once collection finishes, it exposes the RAM through a synchronous readback port to the bench or host. It is the reader counterpart of the ray-memory preload path and sits between the RTP result outputs and the test/host logic.

## Interface
- NUM_RAYS, 1024: number of rays in the batch; result RAM depth.
- ADDR_W, 10: clog2(NUM_RAYS).
- MISS_T, 32'h7F80_0000: hitT value written at clear (+inf, meaning no hit).

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: clear RAM and counters, then begin collecting
- in_valid  in  1  hit record valid
- in_ready  out  1  collector can accept a record
- in_ray_id  in  32  ray index of the record
- in_hitT  in  32  IEEE-754 single hit distance, non-negative
- rtp_finish  in  1  RTP reports all rays retired
- rd_en  in  1  readback request
- rd_addr  in  ADDR_W  readback ray index
- rd_data  out  32  stored hitT, valid the cycle after rd_en
- rd_hit  out  1  ray received at least one record, aligned with rd_data
- collected  out  ADDR_W+1  distinct rays received
- dup_count  out  16  records for already-seen rays, saturating
- oob_err  out  1  sticky: a record arrived with in_ray_id >= NUM_RAYS
- incomplete  out  1  sticky: done was reached via rtp_finish with collected < NUM_RAYS
- busy  out  1  state is CLEAR or COLLECT
- done  out  1  state is DONE
- cycle_count  out  64  cycles from start to entering DONE

## Operation
- FSM states: IDLE, CLEAR, COLLECT, DONE. Reset places the FSM in IDLE.
- IDLE or DONE + start goes to CLEAR. A start received in CLEAR or COLLECT is ignored.
- CLEAR writes MISS_T and clears the seen bit at one address per cycle, for addresses 0..NUM_RAYS-1. In the same cycle as the last write it zeroes collected, dup_count, oob_err and incomplete, then moves to COLLECT.
- COLLECT: in_ready=1. A transfer is in_valid & in_ready.
- Two-stage update pipeline:
  - S1 registers the id and hitT, and reads the stored value and seen bit.
  - S2 computes new = seen ? min(stored, hitT) : hitT and writes it. The minimum is an unsigned compare of the 32-bit patterns, which is valid for non-negative floats. S2 sets the seen bit.
  - S2 increments collected if the ray was unseen; otherwise it increments dup_count.
- Forwarding: if S1's id equals the id in S2, S1 uses S2's write value and seen=1 instead of the RAM read. Back-to-back records for the same id must therefore resolve to the correct minimum.
- Out-of-range id: the record is dropped (no RAM write, no counter change) and oob_err is set.
- COLLECT goes to DONE when either:
  - collected reaches NUM_RAYS with the pipeline empty, or
  - rtp_finish=1 and the pipeline is empty. If collected < NUM_RAYS at that point, incomplete is set.
- DONE: in_ready=0. rd_en returns rd_data and rd_hit on the next cycle. In any other state rd_data=0 and rd_hit=0.
- cycle_count clears on start, increments every cycle in CLEAR and COLLECT, and holds in DONE.

## Timing
- Reset values: in_ready=0, rd_data=0, rd_hit=0, collected=0, dup_count=0, oob_err=0, incomplete=0, busy=0, done=0, cycle_count=0, FSM=IDLE. Reset mid-operation aborts immediately. RAM contents are don't-care after reset until the next CLEAR.
- CLEAR lasts exactly NUM_RAYS cycles. in_ready rises on the first COLLECT cycle.
- Record latency: collected and dup_count update 2 cycles after the transfer. The RAM is written at the end of S2.
- One record per cycle is sustained. There is no backpressure in COLLECT.
- Entering DONE takes 1 cycle after the completion condition is seen with an empty pipeline.
- A record presented in the same cycle as rtp_finish is accepted. DONE then waits for it to drain.
- dup_count saturates at 16'hFFFF.
- Readback latency is 1 cycle. Back-to-back rd_en is supported.

## Structure
- Shared package rtp_pkg holds the FSM state enum coll_state_t, the MISS_T constant, and a hit record struct {ray_id, hitT} for reuse on the RTP output side.
- One sub-module, rtp_result_ram: a single-port-read / single-port-write RAM of NUM_RAYS x 33 bits (hitT plus seen bit). It has a combinational read and a synchronous write.
- The FSM, pipeline, forwarding, counters and readback mux live in the top module.

## Test plan
- Basic fill, NUM_RAYS=8: start, then ids 0..7 with hitT=0x3F800000 + id. Required: done, collected=8, incomplete=0, and readback of id 5 gives 0x3F800005 with rd_hit=1.
- Duplicate minimum with forwarding: back-to-back id 3 with 0x40000000 then 0x3F000000, followed by id 3 again 5 cycles later with 0x40400000. Required: rd_data=0x3F000000 and dup_count=2.
- Early finish: only ids 0..5 sent, then rtp_finish=1. Required: done, incomplete=1, collected=6, and readback of id 7 gives 0x7F800000 with rd_hit=0.
- Out of range: id 8 with NUM_RAYS=8. Required: oob_err=1, collected unchanged, no RAM write.
- Restart and cycle count: a second start from DONE clears all outputs. Then 8 records one per cycle and the last one drained. Required: cycle_count = 8 (CLEAR) + 8 (records) + 2 (drain) + 1.
- Reset mid-COLLECT: assert reset after 3 records. Required: all outputs at reset values and FSM in IDLE; the next start and fill behave as in the first scenario.
